// File: rtl/bidir_bus_arbiter.sv
// Half-duplex bus owner arbiter: grants one of two requesters, drives the buffer
// direction select and per-side enables, and inserts dead cycles on every turnaround.
module bidir_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic oe_a,
    output logic oe_b,
    output logic dir,
    output logic busy,
    output logic preempt
);

    // Handshake: req_x is a level held for the whole transfer; gnt_x/oe_x high means
    // side x may drive this cycle; dropping req_x releases the bus on the next edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        GNT_A = 2'd2,
        GNT_B = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic       target_q, target_d;
    logic       dir_q, dir_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic       preempt_q, preempt_d;

    logic pick;
    logic me;
    logic own_req;
    logic oth_req;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        dir_d        = dir_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        turn_cnt_d   = turn_cnt_q;
        preempt_d    = 1'b0;
        pick         = 1'b0;
        me           = (state_q == GNT_B);
        own_req      = me ? req_b : req_a;
        oth_req      = me ? req_a : req_b;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // On a tie the side that did not own the bus last wins.
                    pick     = (req_a && req_b) ? ~last_owner_q : req_b;
                    target_d = pick;
                    if (pick == dir_q) begin
                        state_d    = pick ? GNT_B : GNT_A;
                        hold_cnt_d = 8'd0;
                    end else begin
                        state_d    = TURN;
                        turn_cnt_d = TURN_LOAD;
                        dir_d      = pick;
                    end
                end
            end
            TURN: begin
                if (turn_cnt_q == 4'd0) begin
                    if (target_q ? req_b : req_a) begin
                        state_d    = target_q ? GNT_B : GNT_A;
                        hold_cnt_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            default: begin
                last_owner_d = me;
                if (!own_req) begin
                    if (oth_req) begin
                        state_d    = TURN;
                        target_d   = ~me;
                        dir_d      = ~me;
                        turn_cnt_d = TURN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (oth_req && hold_cnt_q == HOLD_MAX) begin
                    preempt_d  = 1'b1;
                    state_d    = TURN;
                    target_d   = ~me;
                    dir_d      = ~me;
                    turn_cnt_d = TURN_LOAD;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            target_q     <= 1'b0;
            dir_q        <= 1'b0;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= 8'd0;
            turn_cnt_q   <= 4'd0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            dir_q        <= dir_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            turn_cnt_q   <= turn_cnt_d;
            preempt_q    <= preempt_d;
        end
    end

    assign gnt_a   = (state_q == GNT_A);
    assign gnt_b   = (state_q == GNT_B);
    assign oe_a    = gnt_a;
    assign oe_b    = gnt_b;
    assign dir     = dir_q;
    assign busy    = (state_q != IDLE);
    assign preempt = preempt_q;

endmodule

// File: doc/bidir_bus_arbiter.md
Name: bidir_bus_arbiter

Overview:
Controller that shares one half-duplex bidirectional tristate line pair between requester A and requester B. It grants bus ownership, drives the direction select and the per-side output enables, and inserts dead (turnaround) cycles so that both sides never drive at once. It also enforces round-robin fairness and a maximum hold time. It sits directly above the bidirectional tristate buffer: it generates the select and enable signals that the buffer and the requesters' drivers consume.

Parameters:
TURN_CYCLES, 1, number of dead cycles (both enables low) on a direction change; legal range 1..15
MAX_HOLD, 8, maximum consecutive grant cycles while the other side is requesting; legal range 2..255

Ports:
clk      input   1  single clock; all state changes on the rising edge
rst      input   1  synchronous, active-high reset
req_a    input   1  A requests the bus (level); held high for the whole transfer
req_b    input   1  B requests the bus (level)
gnt_a    output  1  A owns the bus and may drive this cycle
gnt_b    output  1  B owns the bus and may drive this cycle
oe_a     output  1  tristate enable for A's driver (equals gnt_a)
oe_b     output  1  tristate enable for B's driver (equals gnt_b)
dir      output  1  buffer select: 0 = A side drives, 1 = B side drives
busy     output  1  high in any state other than IDLE
preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered, Moore-style, and derived from state.
- Reset values: state=IDLE, gnt_a=gnt_b=oe_a=oe_b=0, dir=0, busy=0, preempt=0, last_owner=B (A wins the first tie), hold_cnt=0, turn_cnt=0.
- States: IDLE, TURN, GNT_A, GNT_B. A target register (0=A, 1=B) records who is granted after TURN.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: that side is the target.
  - Both requests: the side that is not last_owner is the target.
  - If the target side equals dir, go directly to GNT_x. Grant is visible 1 cycle after req is sampled.
  - Otherwise go to TURN, load turn_cnt=TURN_CYCLES-1, and set dir to the target on entry.
- TURN:
  - oe_a=oe_b=0; dir already shows the new owner.
  - Decrement turn_cnt. At 0, go to GNT_target.
  - Total latency for a direction change: 1+TURN_CYCLES cycles from req sample to grant.
  - If the target's request drops during TURN, still finish TURN, then go to IDLE. No grant is issued.
- GNT_A (symmetric for B):
  - gnt_a=oe_a=1; last_owner=A; hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - req_a low: release. If req_b is high, go to TURN toward B; else go to IDLE. Release takes effect the cycle after req_a is sampled low.
  - req_a high, req_b high, and hold_cnt==MAX_HOLD-1: preempt. Pulse preempt for 1 cycle and go to TURN toward B. A keeps req_a and is re-granted after B releases or is preempted.
  - req_b low: A holds the bus indefinitely; hold_cnt stays saturated.
  - hold_cnt clears to 0 on every entry to a GNT state.
- Invariants on every cycle: never oe_a&oe_b; oe_x==gnt_x; dir never changes while any oe is high; every direction change has at least TURN_CYCLES cycles with both oe low.
- Reset asserted mid-grant or mid-turn: on the next edge all outputs return to their reset values and the FSM goes to IDLE. dir returns to 0 even if B was driving, which is safe because both oe are 0.
- Requests asserted during reset are ignored. They are evaluated in the first cycle after rst falls.

Test Plan:
- Reset, then req_a=1 alone at cycle 2 → gnt_a=oe_a=1 at cycle 3 (dir=0, no TURN); req_a=0 at cycle 6 → gnt_a=0 at cycle 7, busy=0.
- After reset, req_b=1 alone, TURN_CYCLES=1 → dir=1 next cycle with oe both 0, then gnt_b=1 the cycle after (latency 2).
- req_a and req_b rise together after reset → A granted first; A drops req after 3 cycles → 1 dead cycle, then gnt_b=1.
- Both held high continuously, MAX_HOLD=8 → gnt_a high exactly 8 cycles, preempt pulses once, 1 dead cycle, gnt_b high 8 cycles, then back to A; never oe_a&oe_b.
- req_b pulses for 1 cycle while in IDLE with dir=0, then drops during TURN → dir=1, no gnt_b ever asserted, FSM returns to IDLE.
- rst=1 while gnt_b=1 and dir=1 → next edge: all outputs 0, dir=0; after rst falls with req_a=1 → gnt_a one cycle later.
